imm_decode_ctrl: RTL and testbench
==================================

# imm_decode_ctrl

Decode-stage controller that sequences the shared immediate sign extender. It accepts fetched instructions over a valid/ready handshake, classifies the opcode, and drives the extender's `ImmSrc` and `in[31:7]` inputs. It registers the 32-bit immediate, PC and classification into a one-cycle output stage with a one-entry skid buffer. The output feeds ID/EX, and the block honours hazard-unit stall and flush.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch offers an instruction.
- if_ready  out  1  block accepts this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  32  instruction PC.
- stall_d  in  1  hazard stall; blocks acceptance.
- flush_d  in  1  hazard flush; discards all held entries.
- imm_src  out  3  to extender `ImmSrc`; combinational from if_instr[6:0].
- se_in  out  25  to extender `in`; equals if_instr[31:7].
- se_out  in  32  extender result.
- ex_valid  out  1  output entry valid.
- ex_ready  in  1  ID/EX consumes.
- ex_imm  out  32  registered immediate.
- ex_pc  out  32  registered PC.
- ex_imm_src  out  3  registered imm_src.
- ex_illegal  out  1  opcode unrecognised.

## Operation
- Opcode map:
  - 0000011, 0010011, 1100111, 1110011 → 000 (I).
  - 0100011 → 001 (S).
  - 1100011 → 010 (B).
  - 1101111 → 011 (J).
  - 0110111, 0010111 → 100 (U).
  - 0110011 (R) → 000, with captured imm forced to 0 and illegal = 0.
  - Any other opcode → 000, imm forced to 0, illegal = 1.
- Accept = if_valid & if_ready.
- Fire = ex_valid & ex_ready.
- if_ready = !reset & !flush_d & !stall_d & (state != SKID).
- On accept, capture {se_out (or 0), if_pc, imm_src, illegal} into the output register, or into the skid register if the output is held.
- FSM states: EMPTY, FULL, SKID.
  - EMPTY: accept → FULL.
  - FULL:
    - accept & fire → FULL, output reloaded.
    - accept & !fire → SKID, entry to skid.
    - !accept & fire → EMPTY.
    - Otherwise hold.
  - SKID: fire → FULL, skid moves to output. No accept in SKID.
- Priority is reset > flush_d > normal. A flush forces EMPTY, and any same-cycle if_valid is dropped.
- Stall does not affect the output side; a held entry can still fire while stall_d = 1.
- Ordering is strictly FIFO.

## Timing
- Latency: accept in cycle N → ex_valid with the data in cycle N+1.
- Throughput: 1 instruction per cycle while ex_ready = 1.
- imm_src and se_in are purely combinational from if_instr. The extender path is combinational and must settle within the cycle.
- ex_* outputs are registered and stay stable while ex_valid & !ex_ready.
- Reset values (apply while reset = 1 and on the cycle after):
  - state EMPTY.
  - ex_valid 0, ex_imm 0, ex_pc 0, ex_imm_src 000, ex_illegal 0.
  - Skid contents 0.
  - if_ready 0 while reset is high, 1 on the first cycle after (given no stall or flush).
- Flush in cycle N → ex_valid = 0 and if_ready = 1 in cycle N+1.
- Reset or flush mid-SKID loses both entries by design.

## Structure
- Package `rv_imm_pkg`:
  - ImmSrc encodings: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U.
  - Opcode constants.
  - FSM state typedef.
- Sub-module `imm_src_decode`: combinational opcode → {imm_src, is_r, illegal}.
- The extender stays external, so a future arbiter can share it.

## Test plan
- Reset held 2 cycles → ex_valid 0, ex_imm 0x00000000, if_ready 0. First cycle after reset → if_ready 1.
- addi x1,x0,-1 (0xFFF00093):
  - Same cycle → imm_src 000.
  - Next cycle → ex_valid 1, ex_imm 0xFFFFFFFF.
- beq x0,x0,-4 (0xFE000EE3):
  - Same cycle → imm_src 010.
  - Next cycle → ex_imm 0xFFFFFFFC, ex_imm_src 010.
- Backpressure, ex_ready 0:
  - Send lui (0x123450B7), then sw x2,8(x1) (0x0020A423) → state SKID, if_ready 0.
  - Raise ex_ready → outputs in order: 0x12345000 (src 100), then 0x00000008 (src 001).
- Flush while in SKID with if_valid 1 → next cycle ex_valid 0, if_ready 1. The dropped instruction never appears.
- Opcode classification:
  - 0x0000007F → ex_illegal 1, ex_imm 0.
  - add (0x002081B3) → ex_illegal 0, ex_imm 0.
  - stall_d 1 with if_valid 1 → no accept; the held output still fires.

Source files
------------

// File: rtl/rv_imm_pkg.sv
// Shared types and constants for the decode-stage immediate path.
package rv_imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // One captured decode result, as held in the output or skid register.
  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] pc;
    imm_src_e    src;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/imm_src_decode.sv
// Opcode classifier: picks the extender format and flags R-type / unknown opcodes.
module imm_src_decode
  import rv_imm_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_src_e   imm_src,
  output logic       is_r,
  output logic       illegal
);

  // Map each opcode to its immediate format; R-type and unknown opcodes use I.
  always_comb begin
    imm_src = IMM_I;
    is_r    = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: imm_src = IMM_I;
      OP_STORE:                            imm_src = IMM_S;
      OP_BRANCH:                           imm_src = IMM_B;
      OP_JAL:                              imm_src = IMM_J;
      OP_LUI, OP_AUIPC:                    imm_src = IMM_U;
      OP_REG:                              is_r    = 1'b1;
      default:                             illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Decode-stage controller: classifies the fetched opcode, steers the external
// sign extender and registers the result into an output stage with a skid slot.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_EMPTY | no entry held; ex_valid low
//   ST_FULL  | output register holds the oldest entry
//   ST_SKID  | output and skid both hold entries; fetch is blocked
module imm_decode_ctrl
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            stall_d,
  input  logic            flush_d,
  output logic [2:0]      imm_src,
  output logic [24:0]     se_in,
  input  logic [XLEN-1:0] se_out,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [2:0]      ex_imm_src,
  output logic            ex_illegal
);

  state_e   state, state_nxt;
  entry_t   out_q, skid_q, in_entry;
  imm_src_e dec_src;
  logic     dec_is_r, dec_illegal;
  logic     accept, fire;
  logic     load_out, load_skid, move_skid;

  imm_src_decode u_dec (
    .opcode  (if_instr[6:0]),
    .imm_src (dec_src),
    .is_r    (dec_is_r),
    .illegal (dec_illegal)
  );

  assign imm_src = dec_src;
  assign se_in   = if_instr[31:7];

  assign if_ready = !reset && !flush_d && !stall_d && (state != ST_SKID);
  assign ex_valid = (state != ST_EMPTY) && !reset;
  assign accept   = if_valid && if_ready;
  assign fire     = ex_valid && ex_ready;

  // R-type and unknown opcodes carry no immediate, so the extender result is dropped.
  always_comb begin
    in_entry         = '0;
    in_entry.imm     = (dec_is_r || dec_illegal) ? '0 : se_out;
    in_entry.pc      = if_pc;
    in_entry.src     = dec_src;
    in_entry.illegal = dec_illegal;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  // Next-state and register load controls; flush discards everything held.
  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush_d) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt = ST_FULL;
            load_out  = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && fire) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_nxt = ST_SKID;
            load_skid = 1'b1;
          end else if (fire) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (fire) begin
            state_nxt = ST_FULL;
            move_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Output and skid data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)       out_q <= in_entry;
      else if (move_skid) out_q <= skid_q;
      if (load_skid)      skid_q <= in_entry;
    end
  end

  assign ex_imm     = out_q.imm;
  assign ex_pc      = out_q.pc;
  assign ex_imm_src = out_q.src;
  assign ex_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Randomised plus directed bench for imm_decode_ctrl with an in-bench
// instruction-level model and an external extender model.
module tb_imm_decode_ctrl;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] pc;
    logic [2:0]  src;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, if_valid, if_ready, stall_d, flush_d, ex_valid, ex_ready, ex_illegal;
  logic [31:0] if_instr, if_pc, se_out, ex_imm, ex_pc;
  logic [2:0]  imm_src, ex_imm_src;
  logic [24:0] se_in;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  bit   zero_exp = 1'b0;

  always #5 clk = ~clk;

  imm_decode_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .stall_d(stall_d), .flush_d(flush_d),
    .imm_src(imm_src), .se_in(se_in), .se_out(se_out), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_imm_src(ex_imm_src),
    .ex_illegal(ex_illegal)
  );

  // Immediate assembled from the instruction fields for a given format.
  function automatic logic [31:0] ext(input logic [2:0] src, input logic [24:0] in25);
    logic [31:0] i;
    i = {in25, 7'b0};
    case (src)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4:    return {i[31:12], 12'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Opcode table: {format, is_r, illegal}.
  function automatic logic [4:0] classify(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: return {3'd0, 2'b00};
      7'b0100011:             return {3'd1, 2'b00};
      7'b1100011:             return {3'd2, 2'b00};
      7'b1101111:             return {3'd3, 2'b00};
      7'b0110111, 7'b0010111: return {3'd4, 2'b00};
      7'b0110011:             return {3'd0, 2'b10};
      default:                return {3'd0, 2'b01};
    endcase
  endfunction

  function automatic exp_t model_entry(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    logic [4:0] c;
    c     = classify(instr[6:0]);
    e.src = c[4:2];
    e.ill = c[0];
    e.imm = (c[1] || c[0]) ? 32'h0 : ext(c[4:2], instr[31:7]);
    e.pc  = pc;
    return e;
  endfunction

  // The external extender, driven from the controller's outputs.
  assign se_out = ext(imm_src, se_in);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_valid();
    return !reset && q.size() > 0;
  endfunction

  function automatic bit model_ready();
    return !reset && !flush_d && !stall_d && q.size() < 2;
  endfunction

  task automatic compare();
    logic [4:0] c;
    c = classify(if_instr[6:0]);
    chk("if_ready", {31'b0, if_ready}, {31'b0, model_ready()});
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, model_valid()});
    chk("imm_src",  {29'b0, imm_src},  {29'b0, c[4:2]});
    chk("se_in",    {7'b0, se_in},     {7'b0, if_instr[31:7]});
    if (model_valid()) begin
      chk("ex_imm",     ex_imm,                {q[0].imm});
      chk("ex_pc",      ex_pc,                 {q[0].pc});
      chk("ex_imm_src", {29'b0, ex_imm_src},   {29'b0, q[0].src});
      chk("ex_illegal", {31'b0, ex_illegal},   {31'b0, q[0].ill});
    end else if (zero_exp) begin
      chk("rst_imm", ex_imm, 32'h0);
      chk("rst_pc",  ex_pc,  32'h0);
      chk("rst_src", {29'b0, ex_imm_src}, 32'h0);
      chk("rst_ill", {31'b0, ex_illegal}, 32'h0);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic update(input bit v, input bit rdy, input bit acc_ok);
    exp_t e;
    if (reset) begin
      q.delete();
      zero_exp = 1'b1;
    end else if (flush_d) begin
      q.delete();
    end else begin
      if (v && acc_ok) e = model_entry(if_instr, if_pc);
      if (rdy) q.pop_front();
      if (v && acc_ok) begin
        q.push_back(e);
        zero_exp = 1'b0;
      end
    end
  endtask

  task automatic step();
    bit fire_m, acc_m;
    #3;
    compare();
    fire_m = model_valid() && ex_ready;
    acc_m  = model_ready();
    @(posedge clk);
    update(if_valid, fire_m, acc_m);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                       input bit rdy, input bit st, input bit fl);
    if_valid = v; if_instr = instr; if_pc = pc; ex_ready = rdy; stall_d = st; flush_d = fl;
    #1;
  endtask

  logic [6:0] ops [12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011,
                           7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011,
                           7'b1111111, 7'b0000000};

  initial begin
    reset = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    step();
    step();
    chk("lit_rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("lit_rst_imm",   ex_imm, 32'h0);
    chk("lit_rst_ready", {31'b0, if_ready}, 32'h0);
    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    chk("lit_ready_after_rst", {31'b0, if_ready}, 32'h1);

    // Model pins against hand-decoded immediates.
    chk("model_addi", model_entry(32'hFFF00093, 0).imm, 32'hFFFFFFFF);
    chk("model_beq",  model_entry(32'hFE000EE3, 0).imm, 32'hFFFFFFFC);
    chk("model_lui",  model_entry(32'h123450B7, 0).imm, 32'h12345000);
    chk("model_sw",   model_entry(32'h0020A423, 0).imm, 32'h00000008);

    drive(1, 32'hFFF00093, 32'h100, 1, 0, 0);
    chk("lit_addi_src", {29'b0, imm_src}, 32'h0);
    step();
    drive(1, 32'hFE000EE3, 32'h104, 1, 0, 0);
    chk("lit_addi_valid", {31'b0, ex_valid}, 32'h1);
    chk("lit_addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("lit_beq_src", {29'b0, imm_src}, 32'h2);
    step();
    chk("lit_beq_imm", ex_imm, 32'hFFFFFFFC);
    chk("lit_beq_exsrc", {29'b0, ex_imm_src}, 32'h2);
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    step();

    // Backpressure into the skid slot, then drain in order.
    drive(1, 32'h123450B7, 32'h200, 0, 0, 0);
    step();
    drive(1, 32'h0020A423, 32'h204, 0, 0, 0);
    step();
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    chk("lit_skid_ready", {31'b0, if_ready}, 32'h0);
    step();
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    chk("lit_lui_imm", ex_imm, 32'h12345000);
    chk("lit_lui_src", {29'b0, ex_imm_src}, 32'h4);
    step();
    chk("lit_sw_imm", ex_imm, 32'h00000008);
    chk("lit_sw_src", {29'b0, ex_imm_src}, 32'h1);
    step();

    // Flush while in SKID with a new instruction offered.
    drive(1, 32'h00100093, 32'h300, 0, 0, 0);
    step();
    drive(1, 32'h00200093, 32'h304, 0, 0, 0);
    step();
    drive(1, 32'h00300093, 32'h308, 0, 0, 1);
    step();
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    chk("lit_flush_valid", {31'b0, ex_valid}, 32'h0);
    chk("lit_flush_ready", {31'b0, if_ready}, 32'h1);
    step();
    step();

    // Classification corner cases.
    drive(1, 32'h0000007F, 32'h400, 1, 0, 0);
    step();
    drive(1, 32'h002081B3, 32'h404, 1, 0, 0);
    chk("lit_ill_flag", {31'b0, ex_illegal}, 32'h1);
    chk("lit_ill_imm", ex_imm, 32'h0);
    step();
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    chk("lit_add_flag", {31'b0, ex_illegal}, 32'h0);
    chk("lit_add_imm", ex_imm, 32'h0);
    step();

    // Stall blocks acceptance but the held entry still fires.
    drive(1, 32'hFFF00093, 32'h500, 1, 1, 0);
    chk("lit_stall_ready", {31'b0, if_ready}, 32'h0);
    chk("lit_stall_valid", {31'b0, ex_valid}, 32'h1);
    step();
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    chk("lit_stall_drained", {31'b0, ex_valid}, 32'h0);
    step();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) ins[6:0] = 7'($urandom);
      reset = ($urandom_range(0, 249) == 0);
      drive($urandom_range(0, 9) < 7, ins, $urandom, $urandom_range(0, 9) < 6,
            $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
      step();
    end

    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    for (int n = 0; n < 4; n++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
